// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two requesters, with a registered valid/ready response.
// Optional saturating grant counters are built when ALU_ARB_STATS_EN is defined.
`ifndef ALU_PASS
`define ALU_PASS 4'd15
`endif

module alu_share_arbiter #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_sel,
    input  logic [XLEN-1:0]   req0_a,
    input  logic [XLEN-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_sel,
    input  logic [XLEN-1:0]   req1_a,
    input  logic [XLEN-1:0]   req1_b,
    output logic [3:0]        alu_sel,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_zero,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   last_grant;

    // Grant: a lone valid requester wins; on a tie the one not granted last time wins.
    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
        req1_ready = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
    end

    // Accept, execute for one cycle, then hold the response until consumed.
    // last_grant doubles as the id of the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_sel    <= `ALU_PASS;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    alu_sel    <= req1_ready ? req1_sel : req0_sel;
                    alu_a      <= req1_ready ? req1_a : req0_a;
                    alu_b      <= req1_ready ? req1_b : req0_b;
                    last_grant <= req1_ready;
                    state      <= EXEC;
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_zero  <= alu_zero;
                    rsp_valid <= 1'b1;
                    rsp_id    <= last_grant;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    alu_sel   <= `ALU_PASS;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating per-requester grant counters; a clear beats a same-cycle grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || stat_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (req1_ready && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, latency, backpressure, async reset and grant counters.
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_OR
`define ALU_OR 4'd3
`endif
`ifndef ALU_PASS
`define ALU_PASS 4'd15
`endif

module tb_alu_share_arbiter;
    localparam int XLEN = 32;
    localparam int STAT_W = 4;
`ifdef ALU_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_sel, req1_sel, alu_sel;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
    logic alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, stat_clr;
    logic [STAT_W-1:0] grant_cnt0, grant_cnt1;
    int checks = 0, failures = 0;

    alu_share_arbiter #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .stat_clr(stat_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    // Behavioural ALU standing in for the real one.
    always_comb begin
        case (alu_sel)
            `ALU_ADD: alu_result = alu_a + alu_b;
            `ALU_SUB: alu_result = alu_a - alu_b;
            `ALU_OR:  alu_result = alu_a | alu_b;
            `ALU_PASS: alu_result = alu_a;
            default:  alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid = 0; req1_valid = 0; stat_clr = 0; rsp_ready = 1;
        req0_sel = `ALU_ADD; req0_a = 0; req0_b = 0;
        req1_sel = `ALU_ADD; req1_a = 0; req1_b = 0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst = 1;
        #2;
        rst = 0;
        step();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_data} !== '0) begin
            failures++;
            $display("FAIL reset_rsp got v=%0b id=%0b z=%0b d=%0h exp all 0", rsp_valid, rsp_id, rsp_zero, rsp_data);
        end
        checks++;
        if ({alu_sel, alu_a, alu_b} !== {`ALU_PASS, 64'd0}) begin
            failures++;
            $display("FAIL reset_alu got sel=%0h a=%0h b=%0h exp sel=%0h a=0 b=0", alu_sel, alu_a, alu_b, `ALU_PASS);
        end
        checks++;
        if ({grant_cnt0, grant_cnt1} !== '0) begin
            failures++;
            $display("FAIL reset_cnt got %0d %0d exp 0 0", grant_cnt0, grant_cnt1);
        end
        rst = 0;
        #1;
    endtask

    task automatic test_single;
        apply_reset();
        req0_valid = 1; req0_sel = `ALU_ADD; req0_a = 5; req0_b = 7;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL single_ready got r0=%0b r1=%0b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 0;
        checks++;
        if ({alu_sel, alu_a, alu_b, rsp_valid} !== {`ALU_ADD, 32'd5, 32'd7, 1'b0}) begin
            failures++;
            $display("FAIL single_exec got sel=%0h a=%0d b=%0d v=%0b exp sel=%0h a=5 b=7 v=0", alu_sel, alu_a, alu_b, rsp_valid, `ALU_ADD);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_data} !== {3'b100, 32'd12}) begin
            failures++;
            $display("FAIL single_rsp got v=%0b id=%0b z=%0b d=%0d exp v=1 id=0 z=0 d=12", rsp_valid, rsp_id, rsp_zero, rsp_data);
        end
        step();
        checks++;
        if ({rsp_valid, alu_sel} !== {1'b0, `ALU_PASS}) begin
            failures++;
            $display("FAIL single_idle got v=%0b sel=%0h exp v=0 sel=%0h", rsp_valid, alu_sel, `ALU_PASS);
        end
    endtask

    task automatic test_tie;
        apply_reset();
        req0_sel = `ALU_SUB; req0_a = 9; req0_b = 9;
        req1_sel = `ALU_OR; req1_a = 32'hF0; req1_b = 32'h0F;
        req0_valid = 1; req1_valid = 1;
        #1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 8 && !(req0_ready || req1_ready); i++) step();
            checks++;
            if ({req1_ready, req0_ready} !== ((k % 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL tie_grant op=%0d got r1r0=%b exp %b", k, {req1_ready, req0_ready}, ((k % 2) ? 2'b10 : 2'b01));
            end
            step();
            step();
            checks++;
            if ({rsp_valid, rsp_id, rsp_zero, rsp_data} !== ((k % 2) ? {3'b110, 32'hFF} : {3'b101, 32'h0})) begin
                failures++;
                $display("FAIL tie_rsp op=%0d got v=%0b id=%0b z=%0b d=%0h", k, rsp_valid, rsp_id, rsp_zero, rsp_data);
            end
            step();
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_backpressure;
        apply_reset();
        rsp_ready = 0;
        req0_valid = 1; req0_sel = `ALU_ADD; req0_a = 1; req0_b = 2;
        step();
        req0_valid = 0;
        req1_valid = 1; req1_sel = `ALU_OR; req1_a = 32'h100; req1_b = 32'h1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, req1_ready} !== {2'b10, 32'd3, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%0b id=%0b d=%0h r1=%0b exp v=1 id=0 d=3 r1=0", i, rsp_valid, rsp_id, rsp_data, req1_ready);
            end
        end
        rsp_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_nobypass got r1=%0b exp 0", req1_ready);
        end
        step();
        checks++;
        if ({rsp_valid, req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release got v=%0b r1=%0b exp v=0 r1=1", rsp_valid, req1_ready);
        end
        req1_valid = 0;
    endtask

    task automatic test_async_reset;
        apply_reset();
        req1_valid = 1; req1_sel = `ALU_ADD; req1_a = 4; req1_b = 4;
        step();
        req1_valid = 0;
        #2;
        rst = 1;
        #1;
        checks++;
        if ({rsp_valid, alu_sel, alu_a} !== {1'b0, `ALU_PASS, 32'd0}) begin
            failures++;
            $display("FAIL arst_exec got v=%0b sel=%0h a=%0h exp v=0 sel=%0h a=0", rsp_valid, alu_sel, alu_a, `ALU_PASS);
        end
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL arst_dropped cyc=%0d got v=%0b exp 0", i, rsp_valid);
            end
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL arst_tie got r1r0=%b exp 01", {req1_ready, req0_ready});
        end
        rsp_ready = 0;
        step();
        req0_valid = 0; req1_valid = 0;
        step();
        step();
        rst = 1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_resp got v=%0b exp 0", rsp_valid);
        end
        rst = 0;
        rsp_ready = 1;
        step();
    endtask

    task automatic do_op(input bit id);
        if (id) req1_valid = 1; else req0_valid = 1;
        #1;
        for (int i = 0; i < 8 && !(id ? req1_ready : req0_ready); i++) step();
        checks++;
        if ((id ? req1_ready : req0_ready) !== 1'b1) begin
            failures++;
            $display("FAIL op_ready id=%0b got 0 exp 1", id);
        end
        step();
        req0_valid = 0; req1_valid = 0;
        step();
        step();
        step();
    endtask

    task automatic test_stats;
        apply_reset();
        for (int i = 0; i < 3; i++) do_op(1'b0);
        for (int i = 0; i < 2; i++) do_op(1'b1);
        checks++;
        if ({grant_cnt0, grant_cnt1} !== (STATS ? {4'd3, 4'd2} : 8'd0)) begin
            failures++;
            $display("FAIL stats_count got %0d %0d exp %0d %0d", grant_cnt0, grant_cnt1, STATS ? 3 : 0, STATS ? 2 : 0);
        end
        stat_clr = 1;
        step();
        stat_clr = 0;
        checks++;
        if ({grant_cnt0, grant_cnt1} !== 8'd0) begin
            failures++;
            $display("FAIL stats_clear got %0d %0d exp 0 0", grant_cnt0, grant_cnt1);
        end
        for (int i = 0; i < 17; i++) do_op(1'b0);
        checks++;
        if (grant_cnt0 !== (STATS ? 4'd15 : 4'd0)) begin
            failures++;
            $display("FAIL stats_saturate got %0d exp %0d", grant_cnt0, STATS ? 15 : 0);
        end
        req0_valid = 1; stat_clr = 1;
        step();
        req0_valid = 0; stat_clr = 0;
        checks++;
        if (grant_cnt0 !== 4'd0) begin
            failures++;
            $display("FAIL stats_clr_wins got %0d exp 0", grant_cnt0);
        end
        step();
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_async_reset();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
